// File: rtl/burst_seq_fsm.sv
// burst_seq_fsm
// Burst sequencer between a requester (do_req/hold) and a datapath that
// consumes r/cnt. A start captures the last beat index, the burst then
// counts beats in RUN, can be paused (PAUSE) or aborted early, always
// finishes with a one-cycle LAST, and is followed by an optional fixed
// idle gap (GAP) before the next start is accepted.
// Output timing classes:
//   g, x, busy : combinational, decoded from state and inputs
//   f, r, cnt, trunc : registered
// The start request is named do_req because "do" is a reserved word.
module burst_seq_fsm #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned GAP_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             do_req,
   input  logic             hold,
   input  logic [CNT_W-1:0] len,
   output logic             g,
   output logic             x,
   output logic             f,
   output logic             r,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             trunc
);

   // Gap length is limited to 15 cycles, so a 4-bit down-counter suffices.
   localparam bit         HAS_GAP  = (GAP_CYC > 0);
   localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP_CYC - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_LAST  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t           state_r;
   state_t           nxt_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] len_q_r;
   logic [3:0]       gap_cnt_r;
   logic             trunc_r;
   logic             f_r;
   logic             r_r;

   logic             g_s;
   logic             x_s;
   logic             busy_s;
   logic             start_s;
   logic             inc_s;
   logic             trunc_wr_s;
   logic             trunc_val_s;
   logic             gap_load_s;
   logic             gap_dec_s;
   logic             nx_r_s;

   // Next-state decode, transition pulses and datapath strobes.
   always_comb begin
      nxt_state_s = S_IDLE;
      g_s         = 1'b0;
      x_s         = 1'b0;
      busy_s      = 1'b0;
      start_s     = 1'b0;
      inc_s       = 1'b0;
      trunc_wr_s  = 1'b0;
      trunc_val_s = 1'b0;
      gap_load_s  = 1'b0;
      gap_dec_s   = 1'b0;
      nx_r_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (do_req) begin
               nxt_state_s = S_RUN;
               g_s         = 1'b1;
               start_s     = 1'b1;
            end else begin
               nxt_state_s = S_IDLE;
            end
         end
         S_RUN: begin
            busy_s = 1'b1;
            if (!do_req) begin
               // Early abort: truncated unless this was the final beat anyway.
               nxt_state_s = S_LAST;
               x_s         = 1'b1;
               trunc_wr_s  = 1'b1;
               trunc_val_s = (cnt_r != len_q_r);
            end else if (cnt_r == len_q_r) begin
               nxt_state_s = S_LAST;
               x_s         = 1'b1;
            end else if (hold) begin
               // The current beat is not consumed; it is replayed on resume.
               nxt_state_s = S_PAUSE;
            end else begin
               nxt_state_s = S_RUN;
               inc_s       = 1'b1;
            end
         end
         S_PAUSE: begin
            busy_s = 1'b1;
            if (!do_req) begin
               nxt_state_s = S_LAST;
               x_s         = 1'b1;
               trunc_wr_s  = 1'b1;
               trunc_val_s = 1'b1;
            end else if (!hold) begin
               nxt_state_s = S_RUN;
            end else begin
               nxt_state_s = S_PAUSE;
            end
         end
         S_LAST: begin
            busy_s = 1'b1;
            g_s    = 1'b1;
            nx_r_s = 1'b1;
            if (HAS_GAP) begin
               nxt_state_s = S_GAP;
               gap_load_s  = 1'b1;
            end else begin
               nxt_state_s = S_IDLE;
            end
         end
         S_GAP: begin
            busy_s = 1'b1;
            if (gap_cnt_r == 4'd0) begin
               nxt_state_s = S_IDLE;
            end else begin
               nxt_state_s = S_GAP;
               gap_dec_s   = 1'b1;
            end
         end
         default: begin
            // Unused codes recover to IDLE with all pulses low.
            nxt_state_s = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= nxt_state_s;
      end
   end

   // Beat counter, captured burst length and sticky truncation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CNT_W{1'b0}};
         len_q_r <= {CNT_W{1'b0}};
         trunc_r <= 1'b0;
      end else if (start_s) begin
         cnt_r   <= {CNT_W{1'b0}};
         len_q_r <= len;
         trunc_r <= 1'b0;
      end else begin
         if (inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (trunc_wr_s) begin
            trunc_r <= trunc_val_s;
         end
      end
   end

   // Inter-burst gap down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_r <= 4'd0;
      end else if (gap_load_s) begin
         gap_cnt_r <= GAP_LOAD;
      end else if (gap_dec_s) begin
         gap_cnt_r <= gap_cnt_r - 4'd1;
      end
   end

   // Registered status: f marks the cycle after LAST, r marks RUN or a LAST exit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_r <= 1'b0;
         r_r <= 1'b0;
      end else begin
         f_r <= (state_r == S_LAST);
         r_r <= (state_r == S_RUN) | nx_r_s;
      end
   end

   // Transition pulses are suppressed while reset is asserted.
   assign g     = g_s & rst_n;
   assign x     = x_s & rst_n;
   assign busy  = busy_s;
   assign f     = f_r;
   assign r     = r_r;
   assign cnt   = cnt_r;
   assign trunc = trunc_r;

endmodule

// File: tb/tb_burst_seq_fsm.sv
// Directed bench for burst_seq_fsm. One instance uses the default gap of
// two cycles, a second instance is built with no GAP state. Each cycle the
// packed vector {g,x,busy,f,r,trunc,cnt} is compared against a
// hand-computed value, sampled 1 time unit after the falling edge.
module tb_burst_seq_fsm;

   logic       clk;
   logic       rst_n;
   logic       do_req;
   logic       hold;
   logic [7:0] len;
   logic       g, x, f, r, busy, trunc;
   logic [7:0] cnt;

   logic       do0;
   logic       hold0;
   logic [7:0] len0;
   logic       g0, x0, f0, r0, busy0, trunc0;
   logic [7:0] cnt0;

   int total;
   int bad;

   burst_seq_fsm #(.CNT_W(8), .GAP_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .do_req(do_req), .hold(hold), .len(len),
      .g(g), .x(x), .f(f), .r(r), .cnt(cnt), .busy(busy), .trunc(trunc)
   );

   burst_seq_fsm #(.CNT_W(8), .GAP_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .do_req(do0), .hold(hold0), .len(len0),
      .g(g0), .x(x0), .f(f0), .r(r0), .cnt(cnt0), .busy(busy0), .trunc(trunc0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      logic [13:0] obs;
      rst_n = 1'b0; do_req = 1'b0; hold = 1'b0; len = 8'd0;
      do0 = 1'b0; hold0 = 1'b0; len0 = 8'd0;
      @(negedge clk); @(negedge clk); #1;
      obs = {g, x, busy, f, r, trunc, cnt};
      total++;
      if (obs !== 14'd0) begin
         bad++; $display("FAIL reset_main got=%b exp=%b", obs, 14'd0);
      end
      obs = {g0, x0, busy0, f0, r0, trunc0, cnt0};
      total++;
      if (obs !== 14'd0) begin
         bad++; $display("FAIL reset_nogap got=%b exp=%b", obs, 14'd0);
      end
      rst_n = 1'b1;
   endtask

   // len=3, do held through the gap, dropped in the first IDLE cycle.
   task automatic test_basic();
      logic [13:0] obs, exp;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         do_req = (c < 8); hold = 1'b0; len = 8'd3;
         #1;
         case (c)
            0: exp = {6'b100000, 8'd0};
            1: exp = {6'b001000, 8'd0};
            2: exp = {6'b001010, 8'd1};
            3: exp = {6'b001010, 8'd2};
            4: exp = {6'b011010, 8'd3};
            5: exp = {6'b101010, 8'd3};
            6: exp = {6'b001110, 8'd3};
            7: exp = {6'b001000, 8'd3};
            default: exp = {6'b000000, 8'd3};
         endcase
         obs = {g, x, busy, f, r, trunc, cnt};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL basic c%0d got=%b exp=%b", c, obs, exp);
         end
      end
   endtask

   // len=5, hold high for three cycles starting at cnt=2.
   task automatic test_pause();
      logic [13:0] obs, exp;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         do_req = (c < 14); hold = (c >= 3 && c <= 5); len = 8'd5;
         #1;
         case (c)
            0:  exp = {6'b100000, 8'd3};
            1:  exp = {6'b001000, 8'd0};
            2:  exp = {6'b001010, 8'd1};
            3:  exp = {6'b001010, 8'd2};
            4:  exp = {6'b001010, 8'd2};
            5:  exp = {6'b001000, 8'd2};
            6:  exp = {6'b001000, 8'd2};
            7:  exp = {6'b001000, 8'd2};
            8:  exp = {6'b001010, 8'd3};
            9:  exp = {6'b001010, 8'd4};
            10: exp = {6'b011010, 8'd5};
            11: exp = {6'b101010, 8'd5};
            12: exp = {6'b001110, 8'd5};
            13: exp = {6'b001000, 8'd5};
            default: exp = {6'b000000, 8'd5};
         endcase
         obs = {g, x, busy, f, r, trunc, cnt};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL pause c%0d got=%b exp=%b", c, obs, exp);
         end
      end
   endtask

   // len=9 aborted at cnt=4, then a len=0 burst clears trunc.
   task automatic test_abort();
      logic [13:0] obs, exp;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         do_req = (c < 5) || (c >= 9 && c < 14); hold = 1'b0;
         len = (c < 9) ? 8'd9 : 8'd0;
         #1;
         case (c)
            0:  exp = {6'b100000, 8'd5};
            1:  exp = {6'b001000, 8'd0};
            2:  exp = {6'b001010, 8'd1};
            3:  exp = {6'b001010, 8'd2};
            4:  exp = {6'b001010, 8'd3};
            5:  exp = {6'b011010, 8'd4};
            6:  exp = {6'b101011, 8'd4};
            7:  exp = {6'b001111, 8'd4};
            8:  exp = {6'b001001, 8'd4};
            9:  exp = {6'b100001, 8'd4};
            10: exp = {6'b011000, 8'd0};
            11: exp = {6'b101010, 8'd0};
            12: exp = {6'b001110, 8'd0};
            13: exp = {6'b001000, 8'd0};
            default: exp = {6'b000000, 8'd0};
         endcase
         obs = {g, x, busy, f, r, trunc, cnt};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL abort c%0d got=%b exp=%b", c, obs, exp);
         end
      end
   endtask

   // len=1 with do held through GAP; restart on first IDLE, then abort at cnt=0.
   task automatic test_back_to_back();
      logic [13:0] obs, exp;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         do_req = (c < 7); hold = 1'b0; len = 8'd1;
         #1;
         case (c)
            0:  exp = {6'b100000, 8'd0};
            1:  exp = {6'b001000, 8'd0};
            2:  exp = {6'b011010, 8'd1};
            3:  exp = {6'b101010, 8'd1};
            4:  exp = {6'b001110, 8'd1};
            5:  exp = {6'b001000, 8'd1};
            6:  exp = {6'b100000, 8'd1};
            7:  exp = {6'b011000, 8'd0};
            8:  exp = {6'b101011, 8'd0};
            9:  exp = {6'b001111, 8'd0};
            10: exp = {6'b001001, 8'd0};
            default: exp = {6'b000001, 8'd0};
         endcase
         obs = {g, x, busy, f, r, trunc, cnt};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL b2b c%0d got=%b exp=%b", c, obs, exp);
         end
      end
   endtask

   // len=0 on the no-gap build: one RUN cycle, LAST straight to IDLE.
   task automatic test_no_gap();
      logic [13:0] obs, exp;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         do0 = (c < 3); hold0 = 1'b0; len0 = 8'd0;
         #1;
         case (c)
            0: exp = {6'b100000, 8'd0};
            1: exp = {6'b011000, 8'd0};
            2: exp = {6'b101010, 8'd0};
            3: exp = {6'b000110, 8'd0};
            default: exp = {6'b000000, 8'd0};
         endcase
         obs = {g0, x0, busy0, f0, r0, trunc0, cnt0};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL nogap c%0d got=%b exp=%b", c, obs, exp);
         end
      end
      do0 = 1'b0;
   endtask

   // Asynchronous reset asserted mid-RUN at cnt=3 with do still high.
   task automatic test_async_reset();
      logic [13:0] obs, exp;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         do_req = 1'b1; hold = 1'b0; len = 8'd7;
         #1;
         case (c)
            0: exp = {6'b100001, 8'd0};
            1: exp = {6'b001000, 8'd0};
            2: exp = {6'b001010, 8'd1};
            3: exp = {6'b001010, 8'd2};
            default: exp = {6'b001010, 8'd3};
         endcase
         obs = {g, x, busy, f, r, trunc, cnt};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL areset_pre c%0d got=%b exp=%b", c, obs, exp);
         end
      end
      #1 rst_n = 1'b0;
      #1;
      obs = {g, x, busy, f, r, trunc, cnt};
      total++;
      if (obs !== 14'd0) begin
         bad++; $display("FAIL areset_immediate got=%b exp=%b", obs, 14'd0);
      end
      @(negedge clk); #1;
      obs = {g, x, busy, f, r, trunc, cnt};
      total++;
      if (obs !== 14'd0) begin
         bad++; $display("FAIL areset_held got=%b exp=%b", obs, 14'd0);
      end
      rst_n = 1'b1; do_req = 1'b0;
      @(negedge clk); #1;
      obs = {g, x, busy, f, r, trunc, cnt};
      total++;
      if (obs !== 14'd0) begin
         bad++; $display("FAIL areset_release got=%b exp=%b", obs, 14'd0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_pause();
      test_abort();
      test_back_to_back();
      test_no_gap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
